// File: rtl/cmos_capture_pack.sv
// OV5640 capture stage: byte-pair packing into RGB565 words for the SDRAM write FIFO.
// Optional frame line-count check enabled by defining CAP_FRAME_CHECK_EN.
module cmos_capture_pack #(
    parameter int unsigned WAIT_FRAMES = 10,
    parameter int unsigned H_PIXELS    = 640,
    parameter int unsigned V_LINES     = 480
) (
    input  logic        clk_write,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        cfg_done,
    output logic        frame_valid,
    output logic        wr_vs,
    output logic        wrf_wrreq,
    output logic [15:0] wrf_din,
    output logic        line_err,
    output logic        frame_err
);

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned WAIT_W = 8;

    localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_LINES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_FRAMES);

    logic              vsync_d0;
    logic              vsync_d1;
    logic              href_d0;
    logic              href_d1;
    logic [7:0]        data_d0;
    logic              byte_flag;
    logic [7:0]        hi_byte;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  line_cnt;

    logic              vs_rise;
    logic              href_fall;
    logic              pair_done;
    logic              write_ok;
    logic [WAIT_W-1:0] wait_next;

    assign vs_rise   = vsync_d0 & ~vsync_d1;
    assign href_fall = ~href_d0 & href_d1;
    assign pair_done = href_d0 & byte_flag;
    // cfg_done gating drops a pair that completes on the edge frame_valid is clearing
    assign write_ok  = frame_valid & cfg_done & (line_cnt < V_LIM) & (pix_cnt < H_LIM);
    assign wait_next = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + WAIT_W'(1);

    // Input registers, packing, geometry counters and warm-up
    always_ff @(posedge clk_write) begin
        if (rst) begin
            vsync_d0    <= 1'b0;
            vsync_d1    <= 1'b0;
            href_d0     <= 1'b0;
            href_d1     <= 1'b0;
            data_d0     <= 8'd0;
            byte_flag   <= 1'b0;
            hi_byte     <= 8'd0;
            wait_cnt    <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            frame_valid <= 1'b0;
            wr_vs       <= 1'b0;
            wrf_wrreq   <= 1'b0;
            wrf_din     <= 16'd0;
            line_err    <= 1'b0;
        end else begin
            vsync_d0  <= cam_vsync;
            vsync_d1  <= vsync_d0;
            href_d0   <= cam_href;
            href_d1   <= href_d0;
            data_d0   <= cam_data;
            wr_vs     <= vsync_d0 & cfg_done;
            wrf_wrreq <= 1'b0;
            line_err  <= 1'b0;

            if (href_d0) begin
                byte_flag <= ~byte_flag;
                if (!byte_flag) begin
                    hi_byte <= data_d0;
                end
            end else begin
                byte_flag <= 1'b0;
            end

            // wrf_din only moves with an accepted write so it holds otherwise
            if (pair_done && write_ok) begin
                wrf_wrreq <= 1'b1;
                wrf_din   <= {hi_byte, data_d0};
            end

            if (vs_rise) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (href_fall) begin
                pix_cnt  <= '0;
                if (line_cnt != CNT_MAX) begin
                    line_cnt <= line_cnt + CNT_W'(1);
                end
                line_err <= frame_valid & ((pix_cnt != H_LIM) | byte_flag);
            end else if (pair_done && (pix_cnt != CNT_MAX)) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end

            if (!cfg_done) begin
                wait_cnt    <= '0;
                frame_valid <= 1'b0;
            end else if (vs_rise) begin
                wait_cnt <= wait_next;
                if (wait_next == WAIT_LIM) begin
                    frame_valid <= 1'b1;
                end
            end
        end
    end

`ifdef CAP_FRAME_CHECK_EN
    logic frame_seen;

    // frame_seen marks that a counted frame is already underway, so its end can be checked
    always_ff @(posedge clk_write) begin
        if (rst) begin
            frame_seen <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (!cfg_done) begin
                frame_seen <= 1'b0;
            end else if (vs_rise && frame_valid) begin
                frame_seen <= 1'b1;
                frame_err  <= frame_seen & (line_cnt != V_LIM);
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_capture_pack.sv
// Directed bench for cmos_capture_pack with WAIT_FRAMES=2, H_PIXELS=4, V_LINES=2.
module tb_cmos_capture_pack;

    localparam int unsigned WAIT_FRAMES = 2;
    localparam int unsigned H_PIXELS    = 4;
    localparam int unsigned V_LINES     = 2;
`ifdef CAP_FRAME_CHECK_EN
    localparam int FERR_EXP = 1;
`else
    localparam int FERR_EXP = 0;
`endif

    logic        clk_write = 1'b0;
    logic        rst;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        cfg_done;
    logic        frame_valid;
    logic        wr_vs;
    logic        wrf_wrreq;
    logic [15:0] wrf_din;
    logic        line_err;
    logic        frame_err;

    cmos_capture_pack #(
        .WAIT_FRAMES(WAIT_FRAMES),
        .H_PIXELS   (H_PIXELS),
        .V_LINES    (V_LINES)
    ) dut (
        .clk_write  (clk_write),
        .rst        (rst),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .cfg_done   (cfg_done),
        .frame_valid(frame_valid),
        .wr_vs      (wr_vs),
        .wrf_wrreq  (wrf_wrreq),
        .wrf_din    (wrf_din),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    always #5 clk_write = ~clk_write;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int lerr_cnt = 0;
    int ferr_cnt = 0;
    logic [15:0] din_q[$];
    int          cyc_q[$];

    always @(posedge clk_write) cyc <= cyc + 1;

    // Output monitor on the inactive edge
    always @(negedge clk_write) begin
        if (wrf_wrreq === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            din_q.push_back(wrf_din);
            cyc_q.push_back(cyc);
        end
        if (line_err === 1'b1) lerr_cnt = lerr_cnt + 1;
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_write);
        cam_href = 1'b1;
        cam_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_write);
            cam_href = 1'b0;
            cam_data = 8'h00;
        end
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] base);
        for (int i = 0; i < nbytes; i++) send_byte(base + 8'(i));
        idle(4);
    endtask

    task automatic vsync_pulse(input bit chk_ws, input logic exp_ws);
        idle(2);
        @(negedge clk_write);
        cam_vsync = 1'b1;
        repeat (3) @(negedge clk_write);
        if (chk_ws) check_eq("wr_vs_in_vsync", 32'(wr_vs), 32'(exp_ws));
        cam_vsync = 1'b0;
        idle(3);
    endtask

    initial begin
        int w0;
        int l0;
        int f0;
        int idx;
        int cd_cyc;

        rst = 1'b1; cfg_done = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;

        // Reset held across active href
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h5A);
        @(negedge clk_write);
        check_eq("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_eq("rst_wr_vs", 32'(wr_vs), 32'd0);
        check_eq("rst_wrreq", 32'(wrf_wrreq), 32'd0);
        check_eq("rst_din", 32'(wrf_din), 32'd0);
        check_eq("rst_line_err", 32'(line_err), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0; cam_href = 1'b0;
        idle(4);

        // Warm-up: frame 1 dropped, frames 2 and 3 captured
        w0 = wr_cnt; l0 = lerr_cnt;
        check_eq("warm_fv_start", 32'(frame_valid), 32'd0);
        vsync_pulse(1'b1, 1'b1);
        send_line(8, 8'h10); send_line(8, 8'h20);
        check_eq("warm_fv_after_f1", 32'(frame_valid), 32'd0);
        check_eq("warm_writes_f1", 32'(wr_cnt - w0), 32'd0);
        vsync_pulse(1'b0, 1'b0);
        check_eq("warm_fv_after_vs2", 32'(frame_valid), 32'd1);
        w0 = wr_cnt;
        send_line(8, 8'h30); send_line(8, 8'h40);
        check_eq("warm_writes_f2", 32'(wr_cnt - w0), 32'd8);
        vsync_pulse(1'b0, 1'b0);
        w0 = wr_cnt;
        send_line(8, 8'h50); send_line(8, 8'h60);
        check_eq("warm_writes_f3", 32'(wr_cnt - w0), 32'd8);
        check_eq("warm_line_err", 32'(lerr_cnt - l0), 32'd0);

        // Packing order and latency
        vsync_pulse(1'b0, 1'b0);
        idx = din_q.size();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        cd_cyc = cyc;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        idle(4);
        check_eq("pack_count", 32'(din_q.size() - idx), 32'd4);
        if (din_q.size() >= idx + 4) begin
            check_eq("pack_word0", 32'(din_q[idx]), 32'h1234);
            check_eq("pack_word1", 32'(din_q[idx+1]), 32'hABCD);
            check_eq("pack_word3", 32'(din_q[idx+3]), 32'h0304);
            check_eq("pack_latency", 32'(cyc_q[idx+1]), 32'(cd_cyc + 2));
        end
        check_eq("pack_din_hold", 32'(wrf_din), 32'h0304);
        check_eq("pack_wrreq_idle", 32'(wrf_wrreq), 32'd0);
        send_line(8, 8'h70);

        // Short and long lines
        vsync_pulse(1'b0, 1'b0);
        w0 = wr_cnt; l0 = lerr_cnt;
        send_line(7, 8'h80);
        check_eq("short_writes", 32'(wr_cnt - w0), 32'd3);
        check_eq("short_line_err", 32'(lerr_cnt - l0), 32'd1);
        w0 = wr_cnt; l0 = lerr_cnt;
        send_line(12, 8'h90);
        check_eq("long_writes", 32'(wr_cnt - w0), 32'd4);
        check_eq("long_line_err", 32'(lerr_cnt - l0), 32'd1);

        // Frame overrun: third line dropped
        vsync_pulse(1'b0, 1'b0);
        w0 = wr_cnt; l0 = lerr_cnt; f0 = ferr_cnt;
        send_line(8, 8'hA0); send_line(8, 8'hB0);
        check_eq("ovr_two_lines", 32'(wr_cnt - w0), 32'd8);
        send_line(8, 8'hC0);
        check_eq("ovr_third_line", 32'(wr_cnt - w0), 32'd8);
        check_eq("ovr_line_err", 32'(lerr_cnt - l0), 32'd0);
        check_eq("ovr_no_early_ferr", 32'(ferr_cnt - f0), 32'd0);
        vsync_pulse(1'b0, 1'b0);
        check_eq("ovr_frame_err", 32'(ferr_cnt - f0), 32'(FERR_EXP));

        // cfg_done drops mid-line after three bytes
        w0 = wr_cnt; l0 = lerr_cnt;
        idx = din_q.size();
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA4); cfg_done = 1'b0;
        send_byte(8'hA5);
        check_eq("drop_fv_next_edge", 32'(frame_valid), 32'd0);
        send_byte(8'hA6); send_byte(8'hA7); send_byte(8'hA8);
        idle(4);
        check_eq("drop_writes", 32'(wr_cnt - w0), 32'd1);
        if (din_q.size() > idx) check_eq("drop_word", 32'(din_q[idx]), 32'hA1A2);
        check_eq("drop_line_err", 32'(lerr_cnt - l0), 32'd0);
        vsync_pulse(1'b1, 1'b0);
        w0 = wr_cnt;
        send_line(8, 8'hD0);
        check_eq("drop_no_writes", 32'(wr_cnt - w0), 32'd0);
        check_eq("drop_fv_stays", 32'(frame_valid), 32'd0);
        check_eq("drop_wr_vs", 32'(wr_vs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
